// File: rtl/dmem_mmio_responder_if.sv
// Data-port and console-drain bundle of dmem_mmio_responder.
// The slave modport is the responder side; master is the core/drain side.
interface dmem_mmio_responder_if;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        timer_irq;
    logic        bus_err;

    modport slave (
        input  MemWrite, ALUResult, WriteData, tx_ready,
        output ReadData, tx_valid, tx_data, timer_irq, bus_err
    );

    modport master (
        output MemWrite, ALUResult, WriteData, tx_ready,
        input  ReadData, tx_valid, tx_data, timer_irq, bus_err
    );
endinterface

// File: rtl/dmem_mmio_responder.sv
// Data RAM, console TX FIFO and optional cycle timer behind the single-cycle core's data port.
// Define DMEM_MMIO_TIMER_EN to build the TIMER / TIMER_CMP registers and timer_irq.
module dmem_mmio_responder #(
    parameter int MEM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_mmio_responder_if.slave bus
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [31:0] CONS_DATA = 32'h8000_0000;
    localparam logic [31:0] CONS_STAT = 32'h8000_0004;

    logic [31:0]   ram [MEM_WORDS];
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          berr_q, berr_d;

    logic          aligned, sel_ram, sel_cdata, sel_cstat, sel_tmr, sel_cmp, mapped;
    logic [AW-1:0] ram_idx;
    logic          push, pop, accept, full, empty;
    logic [31:0]   stat, rdata;

    // Every mapped location is a full aligned address, so only the RAM window needs the alignment test.
    assign aligned   = (bus.ALUResult[1:0] == 2'b00);
    assign sel_ram   = aligned && ((bus.ALUResult >> (AW + 2)) == 32'd0);
    assign sel_cdata = (bus.ALUResult == CONS_DATA);
    assign sel_cstat = (bus.ALUResult == CONS_STAT);
    assign ram_idx   = bus.ALUResult[AW+1:2];

`ifdef DMEM_MMIO_TIMER_EN
    localparam logic [31:0] TIMER     = 32'h8000_0008;
    localparam logic [31:0] TIMER_CMP = 32'h8000_000C;
    assign sel_tmr = (bus.ALUResult == TIMER);
    assign sel_cmp = (bus.ALUResult == TIMER_CMP);
`else
    assign sel_tmr = 1'b0;
    assign sel_cmp = 1'b0;
`endif

    // CONS_STAT is mapped but read-only: a store to it is silently dropped, not a bus error.
    assign mapped = sel_ram || sel_cdata || sel_cstat || sel_tmr || sel_cmp;

    assign full   = (count_q == CW'(FIFO_DEPTH));
    assign empty  = (count_q == '0);
    assign push   = bus.MemWrite && sel_cdata;
    assign pop    = !empty && bus.tx_ready;
    // A pop in the same cycle frees the slot the push lands in, so a full FIFO still accepts.
    assign accept = push && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(accept);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(accept) - CW'(pop);
        ovf_d    = ovf_q || (push && !accept);
        berr_d   = berr_q || (bus.MemWrite && !mapped);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            berr_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            berr_q   <= berr_d;
            if (accept) fifo_q[wr_ptr_q] <= bus.WriteData[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (bus.MemWrite && sel_ram) ram[ram_idx] <= bus.WriteData;
    end

`ifdef DMEM_MMIO_TIMER_EN
    logic [31:0] timer_q, timer_d, cmp_q, cmp_d;
    logic        irq_q, irq_d;

    // A compare write re-arms the flag even on the edge that would otherwise match.
    always_comb begin
        timer_d = (bus.MemWrite && sel_tmr) ? bus.WriteData : timer_q + 32'd1;
        cmp_d   = (bus.MemWrite && sel_cmp) ? bus.WriteData : cmp_q;
        if (bus.MemWrite && sel_cmp) irq_d = 1'b0;
        else                         irq_d = irq_q || (timer_q == cmp_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= 32'd0;
            cmp_q   <= 32'hFFFF_FFFF;
            irq_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            cmp_q   <= cmp_d;
            irq_q   <= irq_d;
        end
    end

    assign bus.timer_irq = irq_q;
`else
    assign bus.timer_irq = 1'b0;
`endif

    assign stat = {23'd0, 5'(count_q), 1'b0, ovf_q, empty, full};

    always_comb begin
        rdata = 32'd0;
        if (sel_ram)        rdata = ram[ram_idx];
        else if (sel_cstat) rdata = stat;
`ifdef DMEM_MMIO_TIMER_EN
        else if (sel_tmr)   rdata = timer_q;
        else if (sel_cmp)   rdata = cmp_q;
`endif
    end

    assign bus.ReadData = rdata;
    assign bus.tx_valid = !empty;
    assign bus.tx_data  = fifo_q[rd_ptr_q];
    assign bus.bus_err  = berr_q;
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Bench for dmem_mmio_responder: directed vector table, hand-written corner sequences
// and randomized traffic checked against a queue/array reference model.
module tb_dmem_mmio_responder;
    localparam int MW = 64;
    localparam int FD = 4;
    localparam logic [31:0] A_CD  = 32'h8000_0000;
    localparam logic [31:0] A_CS  = 32'h8000_0004;
    localparam logic [31:0] A_TM  = 32'h8000_0008;
    localparam logic [31:0] A_CMP = 32'h8000_000C;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_mmio_responder_if ifc();

    dmem_mmio_responder #(.MEM_WORDS(MW), .FIFO_DEPTH(FD)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc.slave)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [31:0] m_ram  [MW];
    bit          m_ramv [MW];
    logic [7:0]  m_q [$];
    bit          m_ovf, m_berr, m_irq;
    logic [31:0] m_timer, m_cmp;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          rdy;
        bit          chk_rd;
        logic [31:0] exp_rd;
        bit          exp_vld;
        logic [7:0]  exp_txd;
    } vec_t;

    vec_t tbl [24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input bit we, input logic [31:0] a, input logic [31:0] d, input bit rdy);
        ifc.MemWrite  = we;
        ifc.ALUResult = a;
        ifc.WriteData = d;
        ifc.tx_ready  = rdy;
    endtask

    function automatic vec_t mk(input bit we, input logic [31:0] a, input logic [31:0] d, input bit rdy,
                                input bit chk, input logic [31:0] er, input bit ev, input logic [7:0] et);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = d; v.rdy = rdy;
        v.chk_rd = chk; v.exp_rd = er; v.exp_vld = ev; v.exp_txd = et;
        return v;
    endfunction

    function automatic logic [31:0] m_stat();
        int n;
        n = m_q.size();
        return 32'((n << 4) + (m_ovf ? 4 : 0) + (n == 0 ? 2 : 0) + (n == FD ? 1 : 0));
    endfunction

    // Returns 0 when the expected value is unknown (RAM word never written).
    function automatic bit m_read(input logic [31:0] a, output logic [31:0] v);
        int idx;
        v = 32'd0;
        if (a[1:0] != 2'b00) return 1'b1;
        if (a < 32'(MW * 4)) begin
            idx = int'(a >> 2);
            v = m_ram[idx];
            return m_ramv[idx];
        end
        if (a == A_CS) v = m_stat();
`ifdef DMEM_MMIO_TIMER_EN
        if (a == A_TM)  v = m_timer;
        if (a == A_CMP) v = m_cmp;
`endif
        return 1'b1;
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_ovf = 0; m_berr = 0; m_irq = 0;
        m_timer = 32'd0;
        m_cmp = 32'hFFFF_FFFF;
    endtask

    task automatic m_edge();
        logic [31:0] a = ifc.ALUResult;
        logic [31:0] d = ifc.WriteData;
        bit          pop = (m_q.size() != 0) && ifc.tx_ready;
        bit          push = 0;
        bit          cmp_wr = 0;
        logic [31:0] nt = m_timer + 32'd1;
        int          idx;
        if (ifc.MemWrite) begin
            if (a[1:0] != 2'b00) m_berr = 1;
            else if (a < 32'(MW * 4)) begin
                idx = int'(a >> 2);
                m_ram[idx] = d;
                m_ramv[idx] = 1;
            end
            else if (a == A_CD) push = 1;
            else if (a == A_CS) begin end
`ifdef DMEM_MMIO_TIMER_EN
            else if (a == A_TM) nt = d;
            else if (a == A_CMP) cmp_wr = 1;
`endif
            else m_berr = 1;
        end
`ifdef DMEM_MMIO_TIMER_EN
        if (cmp_wr) begin
            m_irq = 0;
            m_cmp = d;
        end else if (m_timer == m_cmp) m_irq = 1;
        m_timer = nt;
`endif
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < FD) m_q.push_back(d[7:0]);
            else m_ovf = 1;
        end
    endtask

    task automatic tick();
        if (reset) m_reset();
        else m_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] ev;
        check({tag, ".tx_valid"}, 32'(ifc.tx_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check({tag, ".tx_data"}, 32'(ifc.tx_data), 32'(m_q[0]));
        check({tag, ".bus_err"}, 32'(ifc.bus_err), 32'(m_berr));
        check({tag, ".timer_irq"}, 32'(ifc.timer_irq), 32'(m_irq));
        if (m_read(ifc.ALUResult, ev)) check({tag, ".rdata"}, ifc.ReadData, ev);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [31:0] a, d;
        bit we, rdy;

        tbl[0]  = mk(1, 32'h10, 32'hDEAD_BEEF, 0, 0, 32'h0,        0, 8'h00);
        tbl[1]  = mk(0, 32'h10, 32'h0,         0, 1, 32'hDEAD_BEEF, 0, 8'h00);
        tbl[2]  = mk(1, A_CD,   32'h41,        0, 1, 32'h0,        0, 8'h00);
        tbl[3]  = mk(1, A_CD,   32'h42,        0, 1, 32'h0,        1, 8'h41);
        tbl[4]  = mk(1, A_CD,   32'h143,       0, 1, 32'h0,        1, 8'h41);
        tbl[5]  = mk(1, A_CD,   32'h44,        0, 1, 32'h0,        1, 8'h41);
        tbl[6]  = mk(1, A_CD,   32'h45,        0, 1, 32'h0,        1, 8'h41);
        tbl[7]  = mk(0, A_CS,   32'h0,         0, 1, 32'h045,      1, 8'h41);
        tbl[8]  = mk(0, A_CS,   32'h0,         1, 1, 32'h045,      1, 8'h41);
        tbl[9]  = mk(0, A_CS,   32'h0,         1, 1, 32'h034,      1, 8'h42);
        tbl[10] = mk(0, 32'h10, 32'h0,         1, 1, 32'hDEAD_BEEF, 1, 8'h43);
        tbl[11] = mk(0, A_CS,   32'h0,         1, 1, 32'h014,      1, 8'h44);
        tbl[12] = mk(0, A_CS,   32'h0,         0, 1, 32'h006,      0, 8'h00);
        tbl[13] = mk(1, A_CD,   32'h51,        0, 1, 32'h0,        0, 8'h00);
        tbl[14] = mk(1, A_CD,   32'h52,        0, 1, 32'h0,        1, 8'h51);
        tbl[15] = mk(1, A_CD,   32'h53,        0, 1, 32'h0,        1, 8'h51);
        tbl[16] = mk(1, A_CD,   32'h54,        0, 1, 32'h0,        1, 8'h51);
        tbl[17] = mk(1, A_CD,   32'h55,        1, 1, 32'h0,        1, 8'h51);
        tbl[18] = mk(0, A_CS,   32'h0,         0, 1, 32'h045,      1, 8'h52);
        tbl[19] = mk(0, A_CS,   32'h0,         1, 1, 32'h045,      1, 8'h52);
        tbl[20] = mk(0, A_CS,   32'h0,         1, 1, 32'h034,      1, 8'h53);
        tbl[21] = mk(0, A_CS,   32'h0,         1, 1, 32'h024,      1, 8'h54);
        tbl[22] = mk(0, A_CS,   32'h0,         1, 1, 32'h014,      1, 8'h55);
        tbl[23] = mk(0, A_CS,   32'h0,         0, 1, 32'h006,      0, 8'h00);

        // Reset state
        reset = 1'b1;
        drive(0, A_CS, 32'h0, 0);
        m_reset();
        @(posedge clk);
        #1;
        #1;
        check("rst.tx_valid", 32'(ifc.tx_valid), 32'd0);
        check("rst.tx_data", 32'(ifc.tx_data), 32'd0);
        check("rst.bus_err", 32'(ifc.bus_err), 32'd0);
        check("rst.timer_irq", 32'(ifc.timer_irq), 32'd0);
        check("rst.cons_stat", ifc.ReadData, 32'h002);
        drive(0, A_TM, 32'h0, 0);
        #1;
        check("rst.timer", ifc.ReadData, 32'h0);
        drive(0, A_CMP, 32'h0, 0);
        #1;
`ifdef DMEM_MMIO_TIMER_EN
        check("rst.cmp", ifc.ReadData, 32'hFFFF_FFFF);
`else
        check("rst.cmp_unmapped", ifc.ReadData, 32'h0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed vector table: RAM store/load, FIFO fill, overflow, drain, full push+pop
        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rdy);
            #2;
            if (tbl[i].chk_rd) check($sformatf("vec%0d.rdata", i), ifc.ReadData, tbl[i].exp_rd);
            check($sformatf("vec%0d.tx_valid", i), 32'(ifc.tx_valid), 32'(tbl[i].exp_vld));
            if (tbl[i].exp_vld) check($sformatf("vec%0d.tx_data", i), 32'(ifc.tx_data), 32'(tbl[i].exp_txd));
            check($sformatf("vec%0d.bus_err", i), 32'(ifc.bus_err), 32'd0);
            tick();
        end

        // Misaligned and unmapped stores must not alias into RAM
        drive(1, 32'h0, 32'hA5A5_A5A5, 0); tick();
        drive(1, 32'h4, 32'h1111_1111, 0); tick();
        drive(0, 32'h102, 32'h0, 0); #2;
        check("mis.rd_before", ifc.ReadData, 32'h0);
        check("mis.berr_before", 32'(ifc.bus_err), 32'd0);
        drive(1, 32'h102, 32'h1234_5678, 0); tick();
        #1;
        check("mis.berr_set", 32'(ifc.bus_err), 32'd1);
        drive(1, 32'h4000_0000, 32'hCAFE_F00D, 0); tick();
        drive(1, 32'h6, 32'h7777_7777, 0); tick();
        drive(0, 32'h0, 32'h0, 0); #2;
        check("mis.ram0", ifc.ReadData, 32'hA5A5_A5A5);
        drive(0, 32'h4, 32'h0, 0); #1;
        check("mis.ram1", ifc.ReadData, 32'h1111_1111);
        drive(0, 32'h4000_0000, 32'h0, 0); #1;
        check("mis.rd_unmapped", ifc.ReadData, 32'h0);
        drive(0, 32'h102, 32'h0, 0); #1;
        check("mis.rd_misaligned", ifc.ReadData, 32'h0);
        check("mis.berr_sticky", 32'(ifc.bus_err), 32'd1);
        reset = 1'b1; tick(); reset = 1'b0;

`ifdef DMEM_MMIO_TIMER_EN
        // Timer wrap, compare match, CMP write clearing, and CMP write racing a match
        drive(1, A_TM, 32'hFFFF_FFFE, 0); tick();
        drive(0, A_TM, 32'h0, 0); #2;
        check("tmr.load", ifc.ReadData, 32'hFFFF_FFFE);
        drive(1, A_CMP, 32'h1, 0); tick();
        drive(0, A_TM, 32'h0, 0); #2;
        check("tmr.ffff", ifc.ReadData, 32'hFFFF_FFFF);
        tick(); #1;
        check("tmr.wrap", ifc.ReadData, 32'h0);
        check("tmr.irq_at0", 32'(ifc.timer_irq), 32'd0);
        tick(); #1;
        check("tmr.one", ifc.ReadData, 32'h1);
        check("tmr.irq_at1", 32'(ifc.timer_irq), 32'd0);
        tick(); #1;
        check("tmr.irq_set", 32'(ifc.timer_irq), 32'd1);
        drive(1, A_CMP, 32'h100, 0); tick();
        drive(0, A_CMP, 32'h0, 0); #2;
        check("tmr.irq_clr", 32'(ifc.timer_irq), 32'd0);
        check("tmr.cmp_rd", ifc.ReadData, 32'h100);
        drive(1, A_CMP, 32'h40, 0); tick();
        drive(1, A_TM, 32'h3F, 0); tick();
        drive(0, A_TM, 32'h0, 0); tick();
        drive(1, A_CMP, 32'h200, 0); tick();
        drive(0, A_CMP, 32'h0, 0); #2;
        check("tmr.race_irq", 32'(ifc.timer_irq), 32'd0);
        check_all("tmr.race");
        drive(1, A_TM, 32'h0, 0); tick();
        drive(1, A_CMP, 32'h3, 0); tick();
        drive(0, A_TM, 32'h0, 0); tick(); tick(); tick();
        #1;
        check("tmr.irq_rearm", 32'(ifc.timer_irq), 32'd1);
`else
        // Timer window is unmapped in this build
        drive(0, A_TM, 32'h0, 0); #2;
        check("notmr.rd", ifc.ReadData, 32'h0);
        check("notmr.berr_before", 32'(ifc.bus_err), 32'd0);
        drive(1, A_TM, 32'h1234, 0); tick();
        drive(0, A_TM, 32'h0, 0); #2;
        check("notmr.berr", 32'(ifc.bus_err), 32'd1);
        check("notmr.rd_after", ifc.ReadData, 32'h0);
        check("notmr.irq", 32'(ifc.timer_irq), 32'd0);
        drive(1, A_CMP, 32'h0, 0); tick();
        drive(0, A_CMP, 32'h0, 0); #2;
        check("notmr.cmp_rd", ifc.ReadData, 32'h0);
`endif

        // Asynchronous reset between edges with three bytes queued
        drive(1, 32'h4000_0000, 32'h0, 0); tick();
        drive(1, A_CD, 32'h61, 0); tick();
        drive(1, A_CD, 32'h62, 0); tick();
        drive(1, A_CD, 32'h63, 0); tick();
        drive(0, A_CS, 32'h0, 0); #2;
        check("arst.pre_stat", ifc.ReadData, 32'h030);
        check("arst.pre_berr", 32'(ifc.bus_err), 32'd1);
        check_all("arst.pre");
        #3;
        reset = 1'b1;
        m_reset();
        #1;
        check("arst.tx_valid", 32'(ifc.tx_valid), 32'd0);
        check("arst.tx_data", 32'(ifc.tx_data), 32'd0);
        check("arst.timer_irq", 32'(ifc.timer_irq), 32'd0);
        check("arst.bus_err", 32'(ifc.bus_err), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        check("arst.stat", ifc.ReadData, 32'h002);
        drive(0, A_TM, 32'h0, 0); #1;
        check("arst.timer", ifc.ReadData, 32'h0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                reset = 1'b1; tick(); reset = 1'b0;
            end
            k = int'($urandom_range(0, 99));
            d = $urandom();
            if (k < 35)      a = 32'($urandom_range(0, MW - 1)) << 2;
            else if (k < 60) a = A_CD;
            else if (k < 72) a = A_CS;
            else if (k < 82) begin a = A_TM;  d = 32'($urandom_range(0, 15)); end
            else if (k < 92) begin a = A_CMP; d = 32'($urandom_range(0, 15)); end
            else if (k < 96) a = (32'($urandom_range(0, MW - 1)) << 2) | 32'($urandom_range(1, 3));
            else             a = 32'h4000_0000 | ($urandom() & 32'h0000_00FC);
            we  = ($urandom_range(0, 1) == 1);
            rdy = ($urandom_range(0, 9) < ((i % 300) < 150 ? 1 : 6));
            drive(we, a, d, rdy);
            #2;
            check_all($sformatf("rnd%0d", i));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
